// File: rtl/mem_req_router_if.sv
// Request/response bus shared by the core data port, the RAM and the GPIO block,
// together with the size and response-code encodings used on it.
`ifndef MEM_REQ_ROUTER_DEFS
`define MEM_REQ_ROUTER_DEFS
`define ADDR_W           32
`define WORD_W           32
`define MEM_COUNT_W      2
`define MEM_COUNT_NONE   2'd0
`define MEM_COUNT_BYTE   2'd1
`define MEM_COUNT_HALF   2'd2
`define MEM_COUNT_WORD   2'd3
`define MEM_CODE_W       2
`define MEM_CODE_NONE    2'd0
`define MEM_CODE_READ    2'd1
`define MEM_CODE_WRITE   2'd2
`define MEM_CODE_INVALID 2'd3
`endif

interface mem_req_router_if;
    logic [`ADDR_W-1:0]      addr;
    logic [`WORD_W-1:0]      wr_data;
    logic                    wr_en;
    logic [`MEM_COUNT_W-1:0] count;
    logic [`WORD_W-1:0]      rd_data;
    logic [`MEM_CODE_W-1:0]  code;

    modport master (output addr, wr_data, wr_en, count, input rd_data, code);
    modport slave  (input addr, wr_data, wr_en, count, output rd_data, code);
endinterface

// File: rtl/mem_req_router.sv
// Routes core data-memory requests to RAM or GPIO by address window, returns the
// selected slave's response one cycle later and aborts unmapped/misaligned accesses.
module mem_req_router #(
    parameter logic [`ADDR_W-1:0] MEM_START  = 32'h0000_0000,
    parameter logic [`ADDR_W-1:0] MEM_SIZE   = 32'h0000_1000,
    parameter logic [`ADDR_W-1:0] GPIO_START = 32'h0001_0000,
    parameter logic [`ADDR_W-1:0] GPIO_SIZE  = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               aresetn,
    mem_req_router_if.slave    core,
    mem_req_router_if.master   ram,
    mem_req_router_if.master   gpio,
    input  logic               fault_clr,
    output logic               fault,
    output logic [`ADDR_W-1:0] fault_addr,
    output logic               fault_wr
);
    typedef enum logic [1:0] {CLS_IDLE, CLS_MEM, CLS_GPIO, CLS_ERR} cls_t;

    // Window ends are one bit wider so a window ending at the top of memory does not wrap.
    localparam logic [`ADDR_W:0] MEM_END  = {1'b0, MEM_START} + {1'b0, MEM_SIZE};
    localparam logic [`ADDR_W:0] GPIO_END = {1'b0, GPIO_START} + {1'b0, GPIO_SIZE};

    function automatic logic misaligned(input logic [`MEM_COUNT_W-1:0] cnt,
                                        input logic [1:0] lsb);
        return (cnt == `MEM_COUNT_WORD && lsb != 2'b00) ||
               (cnt == `MEM_COUNT_HALF && lsb[0]);
    endfunction

    logic [`ADDR_W:0] addr_ext;
    logic             hit_mem;
    logic             hit_gpio;
    cls_t             cls_p0;
    cls_t             sel_p1;

    // Stage p0: decode and combinational forwarding
    assign addr_ext = {1'b0, core.addr};
    assign hit_mem  = (addr_ext >= {1'b0, MEM_START})  && (addr_ext < MEM_END);
    assign hit_gpio = (addr_ext >= {1'b0, GPIO_START}) && (addr_ext < GPIO_END);

    always_comb begin
        cls_p0 = CLS_IDLE;
        if (core.count != `MEM_COUNT_NONE) begin
            if (misaligned(core.count, core.addr[1:0]) || !(hit_mem || hit_gpio))
                cls_p0 = CLS_ERR;
            else if (hit_mem)
                cls_p0 = CLS_MEM;
            else
                cls_p0 = CLS_GPIO;
        end
    end

    assign ram.addr     = core.addr;
    assign ram.wr_data  = core.wr_data;
    assign ram.wr_en    = core.wr_en;
    assign ram.count    = (cls_p0 == CLS_MEM) ? core.count : `MEM_COUNT_NONE;
    assign gpio.addr    = core.addr;
    assign gpio.wr_data = core.wr_data;
    assign gpio.wr_en   = core.wr_en;
    assign gpio.count   = (cls_p0 == CLS_GPIO) ? core.count : `MEM_COUNT_NONE;

    // Stage p1: registered target select and response mux
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            sel_p1 <= CLS_IDLE;
        else
            sel_p1 <= cls_p0;
    end

    always_comb begin
        core.rd_data = '0;
        core.code    = `MEM_CODE_NONE;
        case (sel_p1)
            CLS_MEM: begin
                core.rd_data = ram.rd_data;
                core.code    = ram.code;
            end
            CLS_GPIO: begin
                core.rd_data = gpio.rd_data;
                core.code    = gpio.code;
            end
            CLS_ERR:  core.code = `MEM_CODE_INVALID;
            default:  ;
        endcase
    end

    // A new fault outranks a simultaneous clear so it is never lost.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            fault      <= 1'b0;
            fault_addr <= '0;
            fault_wr   <= 1'b0;
        end else if (cls_p0 == CLS_ERR && (!fault || fault_clr)) begin
            fault      <= 1'b1;
            fault_addr <= core.addr;
            fault_wr   <= core.wr_en;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_req_router.sv
// Randomized bench for mem_req_router with a window/alignment reference model,
// a per-cycle compare process, and directed literal checks.
module tb_mem_req_router;
    localparam longint unsigned M_START = 64'h0000_0000, M_SIZE = 64'h0000_1000;
    localparam longint unsigned G_START = 64'h0001_0000, G_SIZE = 64'h0000_0010;
    localparam int C_IDLE = 0, C_MEM = 1, C_GPIO = 2, C_ERR = 3;
    localparam logic [1:0] NONE = 2'd0, BYTE = 2'd1, HALF = 2'd2, WORD = 2'd3;
    localparam logic [1:0] CD_NONE = 2'd0, CD_READ = 2'd1, CD_WRITE = 2'd2, CD_INV = 2'd3;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        fault_clr;
    logic        fault;
    logic [31:0] fault_addr;
    logic        fault_wr;

    always #5 clk = ~clk;

    mem_req_router_if core_bus ();
    mem_req_router_if ram_bus ();
    mem_req_router_if gpio_bus ();

    mem_req_router #(
        .MEM_START(32'h0000_0000), .MEM_SIZE(32'h0000_1000),
        .GPIO_START(32'h0001_0000), .GPIO_SIZE(32'h0000_0010)
    ) dut (
        .clk(clk), .aresetn(aresetn), .core(core_bus), .ram(ram_bus), .gpio(gpio_bus),
        .fault_clr(fault_clr), .fault(fault), .fault_addr(fault_addr), .fault_wr(fault_wr)
    );

    // Slave stubs: one-cycle response, code reflects whether they were addressed
    logic [31:0] ram_val, gpio_val;
    always @(posedge clk) begin
        ram_bus.rd_data  <= ram_val;
        ram_bus.code     <= (ram_bus.count == NONE) ? CD_NONE : (ram_bus.wr_en ? CD_WRITE : CD_READ);
        gpio_bus.rd_data <= gpio_val;
        gpio_bus.code    <= (gpio_bus.count == NONE) ? CD_NONE : (gpio_bus.wr_en ? CD_WRITE : CD_READ);
    end

    int n_pass = 0, n_tot = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model state: exp_* is what the DUT must show now, pend_* after the next edge
    logic [1:0]  exp_ram_cnt, exp_gpio_cnt, exp_code, pend_code;
    logic [31:0] exp_data, pend_data, exp_faddr, pend_faddr;
    logic        exp_fault, pend_fault, exp_fwr, pend_fwr;
    logic [1:0]  fwd_ram, fwd_gpio;

    function automatic int model_class(input logic [1:0] cnt, input logic [31:0] addr);
        longint unsigned a;
        a = 64'(addr);
        if (cnt == NONE) return C_IDLE;
        if ((cnt == WORD && a % 4 != 0) || (cnt == HALF && a % 2 != 0)) return C_ERR;
        if (a >= M_START && a < M_START + M_SIZE) return C_MEM;
        if (a >= G_START && a < G_START + G_SIZE) return C_GPIO;
        return C_ERR;
    endfunction

    task automatic model_reset();
        exp_code = CD_NONE;  exp_data = '0;  pend_code = CD_NONE;  pend_data = '0;
        exp_fault = 1'b0; exp_faddr = '0; exp_fwr = 1'b0;
        pend_fault = 1'b0; pend_faddr = '0; pend_fwr = 1'b0;
        exp_ram_cnt = NONE; exp_gpio_cnt = NONE;
    endtask

    // Called at posedge+1; applies a request, updates the model, returns at next posedge+1
    task automatic drive(input logic [1:0] cnt, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic clr,
                         input logic [31:0] rv, input logic [31:0] gv);
        int c;
        core_bus.count = cnt; core_bus.addr = addr; core_bus.wr_en = wr;
        core_bus.wr_data = wd; fault_clr = clr; ram_val = rv; gpio_val = gv;
        c = model_class(cnt, addr);
        exp_ram_cnt  = (c == C_MEM)  ? cnt : NONE;
        exp_gpio_cnt = (c == C_GPIO) ? cnt : NONE;
        case (c)
            C_MEM:   begin pend_code = wr ? CD_WRITE : CD_READ; pend_data = rv; end
            C_GPIO:  begin pend_code = wr ? CD_WRITE : CD_READ; pend_data = gv; end
            C_ERR:   begin pend_code = CD_INV;  pend_data = '0; end
            default: begin pend_code = CD_NONE; pend_data = '0; end
        endcase
        pend_fault = exp_fault; pend_faddr = exp_faddr; pend_fwr = exp_fwr;
        if (c == C_ERR && (!exp_fault || clr)) begin
            pend_fault = 1'b1; pend_faddr = addr; pend_fwr = wr;
        end else if (clr) begin
            pend_fault = 1'b0;
        end
        #1;
        fwd_ram = ram_bus.count; fwd_gpio = gpio_bus.count;
        @(posedge clk);
        exp_code = pend_code; exp_data = pend_data;
        exp_fault = pend_fault; exp_faddr = pend_faddr; exp_fwr = pend_fwr;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ram_count",   32'(ram_bus.count),  32'(exp_ram_cnt));
            chk("gpio_count",  32'(gpio_bus.count), 32'(exp_gpio_cnt));
            chk("res_code",    32'(core_bus.code),  32'(exp_code));
            chk("res_rd_data", core_bus.rd_data,    exp_data);
            chk("fault",       32'(fault),          32'(exp_fault));
            chk("fault_addr",  fault_addr,          exp_faddr);
            chk("fault_wr",    32'(fault_wr),       32'(exp_fwr));
            chk("bcast_addr",  ram_bus.addr ^ gpio_bus.addr, 32'h0);
            chk("bcast_wdata", gpio_bus.wr_data,    core_bus.wr_data);
            chk("bcast_wr",    32'({ram_bus.wr_en, gpio_bus.wr_en}), 32'({2{core_bus.wr_en}}));
        end
    end

    logic [31:0] edges [11] = '{32'h0, 32'hffc, 32'hffe, 32'hfff, 32'h1000, 32'hfffc,
                               32'h1_0000, 32'h1_000c, 32'h1_000f, 32'h1_0010, 32'hffff_fffc};

    initial begin
        logic [31:0] a;
        aresetn = 1'b1;
        core_bus.count = NONE; core_bus.addr = '0; core_bus.wr_en = 1'b0;
        core_bus.wr_data = '0; fault_clr = 1'b0; ram_val = '0; gpio_val = '0;
        model_reset();
        #1 aresetn = 1'b0;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_code", 32'(core_bus.code), 32'(CD_NONE));
        chk("rst_data", core_bus.rd_data, 32'h0);
        chk("rst_cnts", 32'({ram_bus.count, gpio_bus.count}), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        aresetn = 1'b1;

        // Out-of-window and misaligned accesses
        drive(WORD, 32'h0000_1000, 1'b0, 32'h0, 1'b0, 32'h5555_5555, 32'h6666_6666);
        chk("oob_fwd", 32'({fwd_ram, fwd_gpio}), 32'h0);
        chk("oob_code", 32'(core_bus.code), 32'(CD_INV));
        chk("oob_data", core_bus.rd_data, 32'h0);
        drive(HALF, 32'h0000_0003, 1'b0, 32'h0, 1'b0, 32'h5555_5555, 32'h6666_6666);
        chk("mis_fwd", 32'({fwd_ram, fwd_gpio}), 32'h0);
        chk("mis_code", 32'(core_bus.code), 32'(CD_INV));
        chk("first_faddr", fault_addr, 32'h0000_1000);
        chk("first_fwr", 32'(fault_wr), 32'h0);

        // Clear coinciding with a new fault, then clear alone
        drive(BYTE, 32'h0002_0000, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0);
        chk("clr_err_fault", 32'(fault), 32'h1);
        chk("clr_err_faddr", fault_addr, 32'h0002_0000);
        chk("clr_err_fwr", 32'(fault_wr), 32'h1);
        drive(NONE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
        chk("clr_alone", 32'(fault), 32'h0);

        // GPIO word write
        drive(WORD, 32'h0001_0000, 1'b1, 32'hdead_beef, 1'b0, 32'h0, 32'h7777_7777);
        chk("gpio_wr_fwd_gpio", 32'(fwd_gpio), 32'(WORD));
        chk("gpio_wr_fwd_ram", 32'(fwd_ram), 32'(NONE));
        chk("gpio_wr_code", 32'(core_bus.code), 32'(CD_WRITE));

        // Back-to-back RAM then GPIO reads
        drive(WORD, 32'h0000_0ffc, 1'b0, 32'h0, 1'b0, 32'h1111_1111, 32'h9999_9999);
        chk("b2b_ram_data", core_bus.rd_data, 32'h1111_1111);
        chk("b2b_ram_code", 32'(core_bus.code), 32'(CD_READ));
        drive(WORD, 32'h0001_000c, 1'b0, 32'h0, 1'b0, 32'h8888_8888, 32'h2222_2222);
        chk("b2b_gpio_data", core_bus.rd_data, 32'h2222_2222);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'(M_START) + $urandom_range(0, 32'hfff);
                1:       a = 32'(G_START) + $urandom_range(0, 32'hf);
                2:       a = edges[$urandom_range(0, 10)];
                3:       a = $urandom;
                4:       a = 32'(M_START) + ($urandom_range(0, 32'hfff) & 32'hffc);
                default: a = 32'(G_START) + ($urandom_range(0, 32'hf) & 32'hc);
            endcase
            drive(2'($urandom_range(0, 3)), a, 1'($urandom), $urandom,
                  ($urandom_range(0, 7) == 0), $urandom, $urandom);
        end

        // Asynchronous reset in the response cycle of a GPIO request
        drive(WORD, 32'h0001_0004, 1'b0, 32'h0, 1'b0, 32'h0, 32'habcd_0123);
        chk("pre_rst_code", 32'(core_bus.code), 32'(CD_READ));
        chk("pre_rst_data", core_bus.rd_data, 32'habcd_0123);
        core_bus.count = NONE; fault_clr = 1'b0;
        exp_ram_cnt = NONE; exp_gpio_cnt = NONE;
        #2;
        aresetn = 1'b0;
        model_reset();
        #1;
        chk("async_rst_code", 32'(core_bus.code), 32'(CD_NONE));
        chk("async_rst_data", core_bus.rd_data, 32'h0);
        chk("async_rst_fault", 32'(fault), 32'h0);
        @(posedge clk);
        #1;
        drive(NONE, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        aresetn = 1'b1;
        drive(BYTE, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 32'h0bad_cafe, 32'h0);
        chk("post_rst_data", core_bus.rd_data, 32'h0bad_cafe);
        @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
